bombe_rotor_sequencer: RTL and testbench

BOMBE_ROTOR_SEQUENCER -- requirements
Module: bombe_rotor_sequencer

---
 rtl/bombe_rotor_sequencer.sv | 167 ++++++++++++++++
 tb/tb_bombe_rotor_sequencer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bombe_rotor_sequencer.sv
// bombe_rotor_sequencer
//
// Steps three 26-position rotors (left/middle/right) through every setting,
// odometer-style. The search starts from a loaded initial position. After
// each load or step the rotors get a settling period, and then an external
// checker is asked to evaluate the current position. The search stops on the
// first hit, or once all 17576 positions have been tested.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   start                        begin a search from init_pos_* (IDLE or DONE)
//   abort                        cancel an in-progress search
//   init_pos_l/m/r   [4:0]       starting rotor positions, 0..25
//   test_valid, test_hit         checker handshake result
//   rotor_load                   one-cycle load strobe to all rotors
//   inc_l/m/r                    one-cycle increment strobes per rotor
//   pos_l/m/r        [4:0]       commanded rotor positions
//   test_req                     ask the checker to evaluate pos_*
//   steps            [14:0]      steps taken in the current search
//   busy, done, found, err       status flags
module bombe_rotor_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  init_pos_l,
  input  logic [4:0]  init_pos_m,
  input  logic [4:0]  init_pos_r,
  input  logic        test_valid,
  input  logic        test_hit,
  output logic        rotor_load,
  output logic        inc_l,
  output logic        inc_m,
  output logic        inc_r,
  output logic [4:0]  pos_l,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_r,
  output logic        test_req,
  output logic [14:0] steps,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    TEST,
    STEP,
    DONE
  } state_t;

  localparam logic [14:0] MAX_STEPS   = 15'd17575;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       init_ok;

  assign init_ok = (init_pos_l <= 5'd25) && (init_pos_m <= 5'd25) &&
                   (init_pos_r <= 5'd25);

  // Next-state and strobe decode. Abort wins over every other transition
  // from a busy state, and it also suppresses that cycle's load/increment
  // strobes. This keeps the rotors in agreement with the held pos_* values.
  always_comb begin
    state_next = state;
    rotor_load = 1'b0;
    inc_l      = 1'b0;
    inc_m      = 1'b0;
    inc_r      = 1'b0;
    test_req   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start && init_ok) state_next = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          rotor_load = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (abort) state_next = IDLE;
        else if (settle_cnt == SETTLE_LAST) state_next = TEST;
      end
      TEST: begin
        busy     = 1'b1;
        test_req = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (test_valid) begin
          if (test_hit || (steps == MAX_STEPS)) state_next = DONE;
          else state_next = STEP;
        end
      end
      STEP: begin
        busy = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else begin
          inc_r      = 1'b1;
          inc_m      = (pos_r == 5'd25);
          inc_l      = (pos_r == 5'd25) && (pos_m == 5'd25);
          state_next = SETTLE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start && init_ok) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, settle counter, rotor positions, step count and flags.
  // The positions only change on the decoded strobes, so an abort leaves
  // them at their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      pos_l      <= 5'd0;
      pos_m      <= 5'd0;
      pos_r      <= 5'd0;
      steps      <= 15'd0;
      found      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_next;
      err   <= start && !init_ok && ((state == IDLE) || (state == DONE));

      if ((state == SETTLE) && (state_next == SETTLE)) settle_cnt <= settle_cnt + 4'd1;
      else settle_cnt <= 4'd0;

      if (rotor_load) begin
        pos_l <= init_pos_l;
        pos_m <= init_pos_m;
        pos_r <= init_pos_r;
        steps <= 15'd0;
        found <= 1'b0;
      end

      if (inc_r) begin
        pos_r <= (pos_r == 5'd25) ? 5'd0 : pos_r + 5'd1;
        steps <= steps + 15'd1;
      end
      if (inc_m) pos_m <= (pos_m == 5'd25) ? 5'd0 : pos_m + 5'd1;
      if (inc_l) pos_l <= (pos_l == 5'd25) ? 5'd0 : pos_l + 5'd1;

      if ((state == TEST) && (state_next == DONE)) found <= test_hit;
      if (busy && (state_next == IDLE)) found <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bombe_rotor_sequencer.sv
// tb_bombe_rotor_sequencer
//
// Directed testbench for bombe_rotor_sequencer, built with the default
// SETTLE_CYCLES = 2. Each scenario task drives its own stimulus and compares
// the outputs against hand-computed values.
module tb_bombe_rotor_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  init_pos_l;
  logic [4:0]  init_pos_m;
  logic [4:0]  init_pos_r;
  logic        test_valid;
  logic        test_hit;
  logic        rotor_load;
  logic        inc_l;
  logic        inc_m;
  logic        inc_r;
  logic [4:0]  pos_l;
  logic [4:0]  pos_m;
  logic [4:0]  pos_r;
  logic        test_req;
  logic [14:0] steps;
  logic        busy;
  logic        done;
  logic        found;
  logic        err;

  int total;
  int bad;

  bombe_rotor_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .init_pos_l (init_pos_l),
    .init_pos_m (init_pos_m),
    .init_pos_r (init_pos_r),
    .test_valid (test_valid),
    .test_hit   (test_hit),
    .rotor_load (rotor_load),
    .inc_l      (inc_l),
    .inc_m      (inc_m),
    .inc_r      (inc_r),
    .pos_l      (pos_l),
    .pos_m      (pos_m),
    .pos_r      (pos_r),
    .test_req   (test_req),
    .steps      (steps),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .err        (err)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle. Afterwards the outputs show the new state, and
  // inputs set now are sampled at the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the checker request. A timeout counts as a failed comparison.
  task automatic wait_test_req(input string name);
    int n;
    n = 0;
    while (!test_req && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (test_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s: test_req never rose, got %b expected 1", name, test_req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    test_valid = 1'b0;
    test_hit = 1'b0;
    init_pos_l = 5'd0;
    init_pos_m = 5'd0;
    init_pos_r = 5'd0;
    tick();
    tick();
    total++;
    if ({rotor_load, inc_l, inc_m, inc_r, test_req, busy, done, found, err} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 000000000",
               {rotor_load, inc_l, inc_m, inc_r, test_req, busy, done, found, err});
    end
    total++;
    if ({pos_l, pos_m, pos_r, steps} !== 30'd0) begin
      bad++;
      $display("[TB] FAIL reset_pos: got %0d,%0d,%0d steps %0d expected 0,0,0 steps 0",
               pos_l, pos_m, pos_r, steps);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_hit();
    init_pos_l = 5'd0;
    init_pos_m = 5'd0;
    init_pos_r = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({rotor_load, busy} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL first_load: rotor_load,busy got %b expected 11", {rotor_load, busy});
    end
    tick();
    total++;
    if ({rotor_load, test_req} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL first_settle1: rotor_load,test_req got %b expected 00", {rotor_load, test_req});
    end
    tick();
    total++;
    if (test_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_settle2: test_req got %b expected 0", test_req);
    end
    tick();
    total++;
    if (test_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_test_req: got %b expected 1", test_req);
    end
    test_valid = 1'b1;
    test_hit = 1'b1;
    tick();
    test_valid = 1'b0;
    test_hit = 1'b0;
    total++;
    if ({done, found, busy, test_req} !== 4'b1100 || steps !== 15'd0) begin
      bad++;
      $display("[TB] FAIL first_done: done,found,busy,test_req got %b steps %0d expected 1100 steps 0",
               {done, found, busy, test_req}, steps);
    end
  endtask

  task automatic test_carry();
    init_pos_l = 5'd3;
    init_pos_m = 5'd25;
    init_pos_r = 5'd25;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_test_req("carry_wait1");
    total++;
    if ({pos_l, pos_m, pos_r} !== {5'd3, 5'd25, 5'd25}) begin
      bad++;
      $display("[TB] FAIL carry_loaded: got %0d,%0d,%0d expected 3,25,25", pos_l, pos_m, pos_r);
    end
    test_valid = 1'b1;
    test_hit = 1'b0;
    tick();
    test_valid = 1'b0;
    total++;
    if ({inc_l, inc_m, inc_r, rotor_load} !== 4'b1110) begin
      bad++;
      $display("[TB] FAIL carry_strobes: inc_l,inc_m,inc_r,rotor_load got %b expected 1110",
               {inc_l, inc_m, inc_r, rotor_load});
    end
    tick();
    total++;
    if ({pos_l, pos_m, pos_r} !== {5'd4, 5'd0, 5'd0} || steps !== 15'd1) begin
      bad++;
      $display("[TB] FAIL carry_pos: got %0d,%0d,%0d steps %0d expected 4,0,0 steps 1",
               pos_l, pos_m, pos_r, steps);
    end
    wait_test_req("carry_wait2");
    test_valid = 1'b1;
    test_hit = 1'b1;
    tick();
    test_valid = 1'b0;
    test_hit = 1'b0;
    total++;
    if ({done, found} !== 2'b11 || steps !== 15'd1 || {pos_l, pos_m, pos_r} !== {5'd4, 5'd0, 5'd0}) begin
      bad++;
      $display("[TB] FAIL carry_done: done,found got %b steps %0d pos %0d,%0d,%0d expected 11 steps 1 pos 4,0,0",
               {done, found}, steps, pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_done_err();
    // From DONE with found=1 and pos=(4,0,0): a bad start flags err only.
    init_pos_l = 5'd0;
    init_pos_m = 5'd0;
    init_pos_r = 5'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({err, done, found, busy, rotor_load} !== 5'b11100 || {pos_l, pos_m, pos_r} !== {5'd4, 5'd0, 5'd0}) begin
      bad++;
      $display("[TB] FAIL done_err: err,done,found,busy,load got %b pos %0d,%0d,%0d expected 11100 pos 4,0,0",
               {err, done, found, busy, rotor_load}, pos_l, pos_m, pos_r);
    end
    tick();
    total++;
    if ({err, done} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL done_err_clear: err,done got %b expected 01", {err, done});
    end
  endtask

  task automatic test_exhaustive();
    int n;
    int cnt_r;
    int cnt_m;
    int cnt_l;
    int overlap;
    int first_m;
    n = 0;
    cnt_r = 0;
    cnt_m = 0;
    cnt_l = 0;
    overlap = 0;
    first_m = -1;
    init_pos_l = 5'd0;
    init_pos_m = 5'd0;
    init_pos_r = 5'd0;
    test_valid = 1'b1;
    test_hit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 80000) begin
      if (rotor_load && (inc_l || inc_m || inc_r)) overlap++;
      if (inc_r) cnt_r++;
      if (inc_m) cnt_m++;
      if (inc_l) cnt_l++;
      if (inc_m && first_m < 0) first_m = cnt_r;
      tick();
      n++;
    end
    total++;
    if ({done, found} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL exh_done: done,found got %b expected 10", {done, found});
    end
    total++;
    if (steps !== 15'd17575 || {pos_l, pos_m, pos_r} !== {5'd25, 5'd25, 5'd25}) begin
      bad++;
      $display("[TB] FAIL exh_final: steps %0d pos %0d,%0d,%0d expected steps 17575 pos 25,25,25",
               steps, pos_l, pos_m, pos_r);
    end
    total++;
    if (cnt_r != 17575 || cnt_m != 675 || cnt_l != 25) begin
      bad++;
      $display("[TB] FAIL exh_counts: inc_r %0d inc_m %0d inc_l %0d expected 17575 675 25",
               cnt_r, cnt_m, cnt_l);
    end
    total++;
    if (first_m != 26 || overlap != 0) begin
      bad++;
      $display("[TB] FAIL exh_carry: first inc_m at step %0d overlap %0d expected 26 and 0",
               first_m, overlap);
    end
    for (int i = 0; i < 10; i++) begin
      if (inc_r || inc_m || inc_l) cnt_r++;
      tick();
    end
    test_valid = 1'b0;
    total++;
    if (cnt_r != 17575 || steps !== 15'd17575) begin
      bad++;
      $display("[TB] FAIL exh_no_extra: inc count %0d steps %0d expected 17575 and 17575", cnt_r, steps);
    end
  endtask

  task automatic test_bad_init();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    init_pos_l = 5'd0;
    init_pos_m = 5'd26;
    init_pos_r = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({err, busy, rotor_load} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL bad_init: err,busy,rotor_load got %b expected 100", {err, busy, rotor_load});
    end
    tick();
    total++;
    if ({err, busy, rotor_load} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL bad_init_after: err,busy,rotor_load got %b expected 000", {err, busy, rotor_load});
    end
  endtask

  task automatic test_abort_settle();
    init_pos_l = 5'd1;
    init_pos_m = 5'd2;
    init_pos_r = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, done, found, test_req} !== 4'b0000 || {pos_l, pos_m, pos_r} !== {5'd1, 5'd2, 5'd3}) begin
      bad++;
      $display("[TB] FAIL abort_settle: busy,done,found,test_req got %b pos %0d,%0d,%0d expected 0000 pos 1,2,3",
               {busy, done, found, test_req}, pos_l, pos_m, pos_r);
    end
    tick();
    tick();
    tick();
    total++;
    if ({busy, test_req} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL abort_settle_stay: busy,test_req got %b expected 00", {busy, test_req});
    end
  endtask

  task automatic test_abort_test();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_test_req("abort_test_wait");
    abort = 1'b1;
    test_valid = 1'b1;
    test_hit = 1'b1;
    tick();
    abort = 1'b0;
    test_valid = 1'b0;
    test_hit = 1'b0;
    total++;
    if ({busy, done, found, test_req} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL abort_test: busy,done,found,test_req got %b expected 0000",
               {busy, done, found, test_req});
    end
  endtask

  task automatic test_reset_mid();
    init_pos_l = 5'd0;
    init_pos_m = 5'd0;
    init_pos_r = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      wait_test_req("mid_wait");
      test_valid = 1'b1;
      test_hit = 1'b0;
      tick();
      test_valid = 1'b0;
      tick();
    end
    wait_test_req("mid_wait_final");
    total++;
    if (steps !== 15'd40 || {pos_l, pos_m, pos_r} !== {5'd0, 5'd1, 5'd14}) begin
      bad++;
      $display("[TB] FAIL mid_steps: steps %0d pos %0d,%0d,%0d expected 40 pos 0,1,14",
               steps, pos_l, pos_m, pos_r);
    end
    reset = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    total++;
    if ({rotor_load, inc_l, inc_m, inc_r, test_req, busy, done, found, err} !== 9'b0 ||
        {pos_l, pos_m, pos_r, steps} !== 30'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset: flags %b pos %0d,%0d,%0d steps %0d expected all 0",
               {rotor_load, inc_l, inc_m, inc_r, test_req, busy, done, found, err},
               pos_l, pos_m, pos_r, steps);
    end
    init_pos_l = 5'd2;
    init_pos_m = 5'd5;
    init_pos_r = 5'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_test_req("after_reset_wait");
    test_valid = 1'b1;
    test_hit = 1'b1;
    tick();
    test_valid = 1'b0;
    test_hit = 1'b0;
    total++;
    if ({done, found} !== 2'b11 || steps !== 15'd0 || {pos_l, pos_m, pos_r} !== {5'd2, 5'd5, 5'd7}) begin
      bad++;
      $display("[TB] FAIL after_reset_run: done,found %b steps %0d pos %0d,%0d,%0d expected 11 steps 0 pos 2,5,7",
               {done, found}, steps, pos_l, pos_m, pos_r);
    end
  endtask

  // Scenario sequence; each task leaves the DUT in a known state for the next.
  initial begin
    total = 0;
    bad = 0;
    $display("[TB] bombe_rotor_sequencer directed tests");
    test_reset();
    test_first_hit();
    test_carry();
    test_done_err();
    test_exhaustive();
    test_bad_init();
    test_abort_settle();
    test_abort_test();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
